// File: rtl/ram_sdp_bist_ctrl.sv
// Write-all / read-all LFSR pattern driver and checker for a simple dual-port, async-read RAM.
// Optional first-mismatch capture ports are enabled by defining RAM_BIST_ERR_LOG_EN.
module ram_sdp_bist_ctrl #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] SEED       = 32'h1ACE_B00C
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] din,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_cnt
`ifdef RAM_BIST_ERR_LOG_EN
    ,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_got
`endif
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [31:0]           TAPS     = 32'h8020_0003;
    localparam logic [31:0]           SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [ADDR_WIDTH-1:0] LAST     = {ADDR_WIDTH{1'b1}};

    state_t                  state, state_nxt;
    logic [31:0]             lfsr;
    logic [31:0]             lfsr_nxt;
    logic [ADDR_WIDTH-1:0]   count;
    logic                    last;
    logic                    start_ok;
    logic                    mismatch;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign lfsr_nxt = lfsr_step(lfsr);
    assign last     = (count == LAST);
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign mismatch = (state == READ) && (dout != lfsr[DATA_WIDTH-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_ok) state_nxt = WRITE;
            WRITE:      if (last)     state_nxt = READ;
            READ:       if (last)     state_nxt = DONE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Datapath and status registers; done/pass settle one edge after the last compare lands in err_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we             <= 1'b0;
            write_addr     <= '0;
            din            <= '0;
            read_addr      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            lfsr           <= SEED_EFF;
            count          <= '0;
`ifdef RAM_BIST_ERR_LOG_EN
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
`endif
        end else begin
            if (start_ok) begin
                we             <= 1'b1;
                write_addr     <= '0;
                din            <= SEED_EFF[DATA_WIDTH-1:0];
                lfsr           <= SEED_EFF;
                count          <= '0;
                busy           <= 1'b1;
                done           <= 1'b0;
                pass           <= 1'b0;
                err_cnt        <= '0;
`ifdef RAM_BIST_ERR_LOG_EN
                first_err_addr <= '0;
                first_err_exp  <= '0;
                first_err_got  <= '0;
`endif
            end else if (state == DONE) begin
                done <= 1'b1;
                pass <= (err_cnt == 16'd0);
            end

            if (state == WRITE) begin
                if (last) begin
                    we        <= 1'b0;
                    lfsr      <= SEED_EFF;
                    read_addr <= '0;
                    count     <= '0;
                end else begin
                    write_addr <= count + 1'b1;
                    count      <= count + 1'b1;
                    lfsr       <= lfsr_nxt;
                    din        <= lfsr_nxt[DATA_WIDTH-1:0];
                end
            end

            if (state == READ) begin
                lfsr <= lfsr_nxt;
                if (mismatch) begin
                    err_cnt <= sat_inc(err_cnt);
`ifdef RAM_BIST_ERR_LOG_EN
                    if (err_cnt == 16'd0) begin
                        first_err_addr <= read_addr;
                        first_err_exp  <= lfsr[DATA_WIDTH-1:0];
                        first_err_got  <= dout;
                    end
`endif
                end
                if (last) begin
                    busy <= 1'b0;
                end else begin
                    read_addr <= count + 1'b1;
                    count     <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_sdp_bist_ctrl.sv
// Directed bench for ram_sdp_bist_ctrl: default 4096x32 pass, 16-deep fault/restart/reset runs, SEED=0 run.
module tb_ram_sdp_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Default instance: 4096 x 32
    logic        rst0, start0, we0, busy0, done0, pass0;
    logic [11:0] wa0, ra0;
    logic [31:0] din0, dout0;
    logic [15:0] ec0;
    logic [31:0] mem0 [4096];
    // 16-deep instance with fault injection
    logic        rst1, start1, we1, busy1, done1, pass1, inj1;
    logic [3:0]  wa1, ra1;
    logic [31:0] din1, dout1;
    logic [15:0] ec1;
    logic [31:0] mem1 [16];
    // 4-deep instance with SEED=0
    logic        rst2, start2, we2, busy2, done2, pass2;
    logic [1:0]  wa2, ra2;
    logic [31:0] din2, dout2;
    logic [15:0] ec2;
    logic [31:0] mem2 [4];
`ifdef RAM_BIST_ERR_LOG_EN
    logic [11:0] fea0;
    logic [31:0] fee0, feg0;
    logic [3:0]  fea1;
    logic [31:0] fee1, feg1;
    logic [1:0]  fea2;
    logic [31:0] fee2, feg2;
`endif

    always_ff @(posedge clk) if (we0) mem0[wa0] <= din0;
    always_ff @(posedge clk) if (we1) mem1[wa1] <= din1;
    always_ff @(posedge clk) if (we2) mem2[wa2] <= din2;
    assign dout0 = mem0[ra0];
    assign dout1 = mem1[ra1] ^ ((inj1 && (ra1 == 4'd5 || ra1 == 4'd9)) ? 32'h1 : 32'h0);
    assign dout2 = mem2[ra2];

    ram_sdp_bist_ctrl u0 (
        .clk(clk), .rst(rst0), .start(start0), .we(we0), .write_addr(wa0), .din(din0),
        .read_addr(ra0), .dout(dout0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(ec0)
`ifdef RAM_BIST_ERR_LOG_EN
        , .first_err_addr(fea0), .first_err_exp(fee0), .first_err_got(feg0)
`endif
    );

    ram_sdp_bist_ctrl #(.ADDR_WIDTH(4)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .we(we1), .write_addr(wa1), .din(din1),
        .read_addr(ra1), .dout(dout1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(ec1)
`ifdef RAM_BIST_ERR_LOG_EN
        , .first_err_addr(fea1), .first_err_exp(fee1), .first_err_got(feg1)
`endif
    );

    ram_sdp_bist_ctrl #(.ADDR_WIDTH(2), .SEED(32'h0)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .we(we2), .write_addr(wa2), .din(din2),
        .read_addr(ra2), .dout(dout2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(ec2)
`ifdef RAM_BIST_ERR_LOG_EN
        , .first_err_addr(fea2), .first_err_exp(fee2), .first_err_got(feg2)
`endif
    );

    logic [31:0] dlog  [16];
    logic [31:0] dlog_a[16];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs u1 from just after the start-sampling edge; returns the edge count at which done rose (0 = timeout).
    task automatic run1(input bit pulses, output int done_edge);
        done_edge = 0;
        for (int e = 1; e <= 40; e++) begin
            if (we1) dlog[wa1] = din1;
            if (pulses && (e == 4 || e == 21)) start1 = 1'b1;
            step(1);
            start1 = 1'b0;
            if (done1) begin
                done_edge = e;
                break;
            end
        end
    endtask

    initial begin
        int we_cnt, wa_bad, done_edge, diffs;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; inj1 = 1'b0;
        step(3);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        step(5);

        chk("rst_we",    32'(we0),   32'h0);
        chk("rst_waddr", 32'(wa0),   32'h0);
        chk("rst_din",   din0,       32'h0);
        chk("rst_raddr", 32'(ra0),   32'h0);
        chk("rst_busy",  32'(busy0), 32'h0);
        chk("rst_done",  32'(done0), 32'h0);
        chk("rst_pass",  32'(pass0), 32'h0);
        chk("rst_err",   32'(ec0),   32'h0);

        // Default full pass
        start0 = 1'b1; step(1); start0 = 1'b0;
        chk("p0_we",    32'(we0),   32'h1);
        chk("p0_wa0",   32'(wa0),   32'h0);
        chk("p0_din0",  din0,       32'h1ACE_B00C);
        chk("p0_busy",  32'(busy0), 32'h1);
        step(1);
        chk("p0_wa1",   32'(wa0),   32'h1);
        chk("p0_din1",  din0,       32'h0D67_5806);
        we_cnt = 1; wa_bad = 0; done_edge = 0;
        for (int e = 2; e <= 8300; e++) begin
            if (we0) begin
                if (wa0 != 12'(we_cnt)) wa_bad++;
                we_cnt++;
            end
            step(1);
            if (done0) begin
                done_edge = e;
                break;
            end
        end
        chk("p0_we_cycles", 32'(we_cnt),    32'd4096);
        chk("p0_wa_seq",    32'(wa_bad),    32'd0);
        chk("p0_done_edge", 32'(done_edge), 32'd8193);
        chk("p0_pass",      32'(pass0),     32'h1);
        chk("p0_err",       32'(ec0),       32'h0);
        chk("p0_busy_end",  32'(busy0),     32'h0);
        chk("p0_wa_hold",   32'(wa0),       32'd4095);

        // Injected faults at read addresses 5 and 9
        inj1 = 1'b1;
        start1 = 1'b1; step(1); start1 = 1'b0;
        run1(1'b0, done_edge);
        chk("f_done_edge", 32'(done_edge), 32'd33);
        chk("f_err",       32'(ec1),       32'd2);
        chk("f_pass",      32'(pass1),     32'h0);
`ifdef RAM_BIST_ERR_LOG_EN
        chk("f_first_addr", 32'(fea1),  32'd5);
        chk("f_first_xor",  feg1 ^ fee1, 32'h1);
`endif

        // Restart from DONE with start pulses during WRITE and READ
        inj1 = 1'b0;
        start1 = 1'b1; step(1); start1 = 1'b0;
        chk("r_err_clr",  32'(ec1),   32'h0);
        chk("r_done_clr", 32'(done1), 32'h0);
        chk("r_busy",     32'(busy1), 32'h1);
        run1(1'b1, done_edge);
        chk("r_done_edge", 32'(done_edge), 32'd33);
        chk("r_pass",      32'(pass1),     32'h1);
        chk("r_din0",      dlog[0],        32'h1ACE_B00C);
        chk("r_din1",      dlog[1],        32'h0D67_5806);
        for (int i = 0; i < 16; i++) dlog_a[i] = dlog[i];
        start1 = 1'b1; step(1); start1 = 1'b0;
        run1(1'b0, done_edge);
        diffs = 0;
        for (int i = 0; i < 16; i++) if (dlog[i] !== dlog_a[i]) diffs++;
        chk("r2_done_edge", 32'(done_edge), 32'd33);
        chk("r2_din_same",  32'(diffs),     32'd0);
        chk("r2_pass",      32'(pass1),     32'h1);

        // Asynchronous reset in READ cycle 7
        start1 = 1'b1; step(1); start1 = 1'b0;
        step(23);
        chk("a_raddr7", 32'(ra1),   32'd7);
        chk("a_busy",   32'(busy1), 32'h1);
        #2 rst1 = 1'b1;
        #1;
        chk("a_we",    32'(we1),   32'h0);
        chk("a_waddr", 32'(wa1),   32'h0);
        chk("a_din",   din1,       32'h0);
        chk("a_raddr", 32'(ra1),   32'h0);
        chk("a_busy0", 32'(busy1), 32'h0);
        chk("a_done",  32'(done1), 32'h0);
        chk("a_pass",  32'(pass1), 32'h0);
        chk("a_err",   32'(ec1),   32'h0);
        #1 rst1 = 1'b0;
        step(1);
        start1 = 1'b1; step(1); start1 = 1'b0;
        run1(1'b0, done_edge);
        chk("a2_done_edge", 32'(done_edge), 32'd33);
        chk("a2_pass",      32'(pass1),     32'h1);

        // SEED=0 replaced by 1, 4-deep
        start2 = 1'b1; step(1); start2 = 1'b0;
        chk("s_din0", din2, 32'h0000_0001);
        step(1);
        chk("s_din1", din2, 32'h8020_0003);
        step(1);
        chk("s_din2", din2, 32'hC030_0002);
        step(1);
        chk("s_din3", din2, 32'h6018_0001);
        done_edge = 0;
        for (int e = 4; e <= 20; e++) begin
            step(1);
            if (done2) begin
                done_edge = e;
                break;
            end
        end
        chk("s_done_edge", 32'(done_edge), 32'd9);
        chk("s_pass",      32'(pass2),     32'h1);
        chk("s_err",       32'(ec2),       32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
